// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one font ROM among text renderers, one grant per cycle, with each read
// tagged through the ROM latency. Define FONT_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module font_rom_arbiter #(
  parameter int NREQ    = 3,
  parameter int CODE_W  = 4,
  parameter int ROW_W   = 4,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arb_en,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CODE_W-1:0]   req_code,
  input  logic [NREQ*ROW_W-1:0]    req_row,
  output logic [NREQ-1:0]          gnt,
  output logic                     rom_en,
  output logic [CODE_W-1:0]        rom_code,
  output logic [ROW_W-1:0]         rom_row,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]              gnt_q, gnt_d;
  logic                         rom_en_q, rom_en_d;
  logic [CODE_W-1:0]            rom_code_q, rom_code_d;
  logic [ROW_W-1:0]             rom_row_q, rom_row_d;
  logic [ID_W-1:0]              id_q, id_d;
  logic [NREQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]            rsp_data_q, rsp_data_d;
  logic                         busy_q, busy_d;
  logic [ROM_LAT-1:0]           pv_q, pv_d;
  logic [ROM_LAT-1:0][ID_W-1:0] pid_q, pid_d;
  logic [NREQ-1:0]              elig;
  logic                         found;
  logic [ID_W-1:0]              win_id;
`ifndef FONT_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic                         hi_found;
  logic [ID_W-1:0]              hi_id;
`endif

  // Masking with the current grant forces a one-cycle turnaround on a held request.
  assign elig = req & ~gnt_q & {NREQ{arb_en}};

`ifdef FONT_ARB_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
    end
  end
`else
  // Lowest eligible index at or above the pointer wins; otherwise wrap to the lowest eligible.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    hi_found = 1'b0;
    hi_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found  = 1'b1;
        win_id = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
    if (hi_found) win_id = hi_id;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    gnt_d      = '0;
    rom_en_d   = found;
    rom_code_d = rom_code_q;
    rom_row_d  = rom_row_q;
    id_d       = id_q;
    if (found) begin
      gnt_d[win_id] = 1'b1;
      rom_code_d    = req_code[win_id*CODE_W +: CODE_W];
      rom_row_d     = req_row[win_id*ROW_W +: ROW_W];
      id_d          = win_id;
    end
  end

  // Tag pipeline: stage 0 captures the read issued in the current rom_en cycle.
  for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign pv_d[gi]  = rom_en_q;
      assign pid_d[gi] = id_q;
    end else begin : g_tail
      assign pv_d[gi]  = pv_q[gi-1];
      assign pid_d[gi] = pid_q[gi-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pv_q[ROM_LAT-1]) begin
      rsp_valid_d[pid_q[ROM_LAT-1]] = 1'b1;
      rsp_data_d                    = rom_data;
    end
    busy_d = rom_en_d | (|pv_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q       <= '0;
      rom_en_q    <= 1'b0;
      rom_code_q  <= '0;
      rom_row_q   <= '0;
      id_q        <= '0;
      pv_q        <= '0;
      pid_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      rom_en_q    <= rom_en_d;
      rom_code_q  <= rom_code_d;
      rom_row_q   <= rom_row_d;
      id_q        <= id_d;
      pv_q        <= pv_d;
      pid_q       <= pid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rom_en    = rom_en_q;
  assign rom_code  = rom_code_q;
  assign rom_row   = rom_row_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter: directed steps plus random traffic against a transaction-level model.
module tb_font_rom_arbiter;

  localparam int NREQ = 3;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arb_en;
  logic [2:0]  req;
  logic [11:0] req_code, req_row;
  logic [2:0]  gnt;
  logic        rom_en;
  logic [3:0]  rom_code, rom_row;
  logic [7:0]  rom_data;
  logic [2:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  always #5 clk = ~clk;

  font_rom_arbiter #(.NREQ(NREQ), .CODE_W(4), .ROW_W(4), .DATA_W(8), .ROM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .req(req), .req_code(req_code), .req_row(req_row),
    .gnt(gnt), .rom_en(rom_en), .rom_code(rom_code), .rom_row(rom_row), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic logic [7:0] rom_fn(input logic [3:0] c, input logic [3:0] r);
    return {c, r} ^ 8'h4F;
  endfunction

  // ROM model: returns data LAT cycles after rom_en, garbage otherwise.
  logic [7:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en ? rom_fn(rom_code, rom_row) : 8'($urandom);
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  typedef struct { int id; logic [7:0] data; int due; } rsp_t;
  rsp_t       inflight[$];
  int         cyc = 0, m_ptr = 0;
  logic [2:0] m_gnt = '0;
  logic [3:0] m_code = '0, m_row = '0;
  int         vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    m_ptr  = 0;
    m_gnt  = '0;
    m_code = '0;
    m_row  = '0;
  endtask

  // One clock edge of the reference: pick the first eligible requester from the search start.
  task automatic model_edge();
    int w;
    cyc++;
    if (!reset) begin
      model_reset();
      return;
    end
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
`ifdef FONT_ARB_FIXED_PRIO_EN
      i = k;
`else
      i = (m_ptr + k) % NREQ;
`endif
      if (w < 0 && req[i] && arb_en && !m_gnt[i]) w = i;
    end
    if (w >= 0) begin
      m_gnt  = 3'(1 << w);
      m_code = req_code[w*4 +: 4];
      m_row  = req_row[w*4 +: 4];
      m_ptr  = (w + 1) % NREQ;
      inflight.push_back('{w, rom_fn(m_code, m_row), cyc + LAT + 1});
    end else begin
      m_gnt = '0;
    end
  endtask

  task automatic tick();
    logic [2:0] ev;
    logic [7:0] ed;
    @(posedge clk);
    model_edge();
    #1;
    ev = '0;
    ed = '0;
    if (inflight.size() > 0 && inflight[0].due == cyc) begin
      ev = 3'(1 << inflight[0].id);
      ed = inflight[0].data;
      void'(inflight.pop_front());
    end
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("rom_en", 32'(rom_en), 32'(m_gnt != 0));
    check("rom_code", 32'(rom_code), 32'(m_code));
    check("rom_row", 32'(rom_row), 32'(m_row));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev != 0) check("rsp_data", 32'(rsp_data), 32'(ed));
    check("busy", 32'(busy), 32'(inflight.size() > 0));
    $display("cyc %0d req=%b arb_en=%b gnt=%b rom_en=%b code=%h row=%h rsp_valid=%b rsp_data=%h busy=%b",
             cyc, req, arb_en, gnt, rom_en, rom_code, rom_row, rsp_valid, rsp_data, busy);
  endtask

  logic [2:0] seq [6];
  logic [2:0] resume_exp;
  int         cnt;

  initial begin
    arb_en   = 1'b0;
    req      = '0;
    req_code = '0;
    req_row  = '0;
    #2 reset = 1'b0;
    model_reset();
    tick();
    tick();
    #2 reset = 1'b1;
    arb_en = 1'b1;
    tick();

    // Single read for requester 1
    req      = 3'b010;
    req_code = {4'h5, 4'h7, 4'h2};
    req_row  = {4'h1, 4'h3, 4'hE};
    tick();
    check("single_gnt", 32'(gnt), 32'h2);
    check("single_code", 32'(rom_code), 32'h7);
    check("single_row", 32'(rom_row), 32'h3);
    req = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k < LAT + 1) begin
        check("single_early", 32'(rsp_valid), 32'h0);
      end else begin
        check("single_rsp_valid", 32'(rsp_valid), 32'h2);
        check("single_rsp_data", 32'(rsp_data), 32'h3C);
      end
    end

    // Reset with a read in flight
    req = 3'b100;
    tick();
    req = '0;
    tick();
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rom_en", 32'(rom_en), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rom_code", 32'(rom_code), 32'h0);
    req      = 3'b111;
    req_code = 12'($urandom);
    req_row  = 12'($urandom);
    tick();
    tick();
    reset = 1'b1;

    // Contention: all requesters held
`ifdef FONT_ARB_FIXED_PRIO_EN
    seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`else
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    for (int k = 0; k < 6; k++) begin
      tick();
      check("contention_gnt", 32'(gnt), 32'(seq[k]));
    end
    req = '0;
    for (int k = 0; k < LAT + 2; k++) tick();

    // Turnaround: requester 0 alone
    req = 3'b001;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("turn_gnt0", 32'(gnt[0]), 32'(k % 2 == 0));
      cnt += int'(rsp_valid[0]);
    end
    req = '0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      cnt += int'(rsp_valid[0]);
    end
    check("turn_rsp_count", 32'(cnt), 32'd3);

    // arb_en low: no grants, pipeline drains, pointer kept
    req = 3'b111;
    for (int k = 0; k < 3; k++) tick();
    arb_en = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      check("arboff_gnt", 32'(gnt), 32'h0);
      check("arboff_rom_en", 32'(rom_en), 32'h0);
    end
    check("arboff_busy", 32'(busy), 32'h0);
    arb_en = 1'b1;
`ifdef FONT_ARB_FIXED_PRIO_EN
    resume_exp = 3'b001;
`else
    resume_exp = 3'b010;
`endif
    tick();
    check("resume_gnt", 32'(gnt), 32'(resume_exp));
    req = '0;
    for (int k = 0; k < LAT + 2; k++) tick();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      req      = 3'($urandom_range(0, 7));
      arb_en   = ($urandom_range(0, 7) != 0);
      req_code = 12'($urandom);
      req_row  = 12'($urandom);
      tick();
    end
    req    = '0;
    arb_en = 1'b1;
    for (int k = 0; k < LAT + 2; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single character font ROM (digit code + glyph row -> 8-bit pixel row) among several on-screen text renderers: date digits, clock digits and programming-cursor overlay.
- Accepts level requests and grants one requester per cycle, round-robin.
- Drives the ROM address and routes the returned row back to the granted requester with a one-hot valid, tagged through the ROM latency.
- Sits between the renderers and the font ROM / character decoder.

Parameters:
- NREQ, 3, number of requesters (2..8).
- CODE_W, 4, width of the digit/character code.
- ROW_W, 4, width of the glyph row index.
- DATA_W, 8, width of a ROM row.
- ROM_LAT, 1, ROM read latency in clk cycles (1..4), counted from the cycle rom_en is high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- arb_en  in  1  when low, no new grants are issued; in-flight reads still complete.
- req  in  NREQ  level request per requester.
- req_code  in  NREQ*CODE_W  per-requester code; requester i occupies bits [i*CODE_W +: CODE_W].
- req_row  in  NREQ*ROW_W  per-requester row, packed the same way.
- gnt  out  NREQ  one-hot registered grant; at most one bit high.
- rom_en  out  1  ROM read enable, registered.
- rom_code  out  CODE_W  code presented to ROM/decoder, registered.
- rom_row  out  ROW_W  row presented to ROM, registered.
- rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_en.
- rsp_valid  out  NREQ  one-hot; bit i high for one cycle when rsp_data belongs to requester i.
- rsp_data  out  DATA_W  registered copy of rom_data.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt, rom_en, rom_code, rom_row, rsp_valid, rsp_data and busy all go to 0.
  - Round-robin pointer goes to 0 and the tag pipeline is flushed.
  - Reads in flight at reset are discarded; no rsp_valid is ever emitted for them.
- Eligibility: requester i is eligible when req[i]=1, arb_en=1 and gnt[i]=0 in the current cycle. This gives a mandatory one-cycle turnaround so a held req is never double-granted.
- Selection: search starts at the pointer p and runs upward with wrap-around; the first eligible index wins.
- On each rising edge with a winner w:
  - gnt gets one-hot(w); rom_en=1.
  - rom_code and rom_row take the slice-w values sampled at that edge.
  - p becomes (w+1) mod NREQ.
- With no winner: gnt=0, rom_en=0, p unchanged, rom_code/rom_row hold their last values.
- Requester protocol: drop or change req in the cycle gnt[i] is seen. If req[i] is still 1 on the next edge, it is a new request.
- Tag pipeline: ROM_LAT stages carry {valid, id} from the rom_en cycle. When a stage exits:
  - rsp_valid = one-hot(id) and rsp_data = rom_data, both registered.
  - Total latency is ROM_LAT+1 cycles from gnt to rsp_valid.
  - Back-to-back grants give back-to-back responses, in grant order.
- busy = OR of all pipeline valid bits, or rom_en.
- arb_en falling: takes effect at the next edge (no new gnt); the pipeline drains normally.
- All requesters asserting continuously: grants rotate 0,1,2,0,... with one grant per cycle.
- A single requester asserting continuously gets a grant every other cycle.
- Widths: the ID tag is clog2(NREQ) bits with a minimum of 1. No arithmetic beyond the modulo pointer increment; NREQ need not be a power of two.

Optional Feature:
- FONT_ARB_FIXED_PRIO_EN defined:
  - Round-robin is replaced by fixed priority; the lowest index wins.
  - The pointer register is removed.
  - The turnaround rule still applies, so a lower-priority requester gets a slot at least every other cycle when requester 0 holds req.
- Undefined: round-robin as described above.

Test Plan:
- Reset check: reset=0 mid-stream with a read in flight (ROM_LAT=2), then release. All outputs stay 0, no stale rsp_valid appears, and the first grant after release goes to requester 0 when req=3'b111.
- Single read: req=3'b010, code1=4'h7, row1=4'h3; ROM model returns 8'h3C. Response: gnt=3'b010 one cycle, rom_code=7, rom_row=3, then rsp_valid=3'b010 with rsp_data=8'h3C exactly ROM_LAT+1 cycles after gnt.
- Contention: req=3'b111 held for 6 cycles. Grant sequence is 001,010,100,001,010,100 and responses return in the same order with matching data.
- Turnaround: only req[0] held for 6 cycles. gnt[0] pattern is 1,0,1,0,1,0 and exactly three responses arrive.
- arb_en low: arb_en=0 with req=3'b111. No gnt or rom_en; busy drops after the in-flight reads drain; grants resume at the saved pointer when arb_en returns to 1.
- FONT_ARB_FIXED_PRIO_EN build: req=3'b111 held. Grants alternate 001,010,001,010 and requester 2 is never granted.
